// File: rtl/cpu_trace_formatter.sv
// CPU trace formatter: serializes register/memory write records into ASCII text, one char per handshake.
// Optional build macro TRACE_NEWLINE_EN appends an 8'h0A terminator after '#'.
module cpu_trace_formatter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        sat,
  output logic [3:0]  dbg_state_o
);

  // Handshakes: a record transfers on an edge with in_valid && in_ready; a char
  // transfers on an edge with char_valid && char_ready, and char/char_valid hold otherwise.
  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SPACE, S_MARK,
    S_REGNUM, S_ADDR, S_ARROW, S_DATA, S_HASH, S_NL
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        kind_q;
  logic [3:0]  tdig_q [4];
  logic [2:0]  tlen_q;
  logic [3:0]  rtens_q, rones_q;
  logic        rtwo_q;
  logic [31:0] pc_q, addr_q, data_q;
  logic        sat_q;

  logic        accept;
  logic        over;
  logic [13:0] t_clip;
  logic [3:0]  t_d3, t_d2, t_d1, t_d0;
  logic [2:0]  t_len;
  logic [1:0]  t_sel;
  logic        seg_last;
  state_t      seg_next;

  function automatic logic [3:0] nib_sel(input logic [31:0] w, input logic [2:0] i);
    case (i)
      3'd0:    return w[31:28];
      3'd1:    return w[27:24];
      3'd2:    return w[23:20];
      3'd3:    return w[19:16];
      3'd4:    return w[15:12];
      3'd5:    return w[11:8];
      3'd6:    return w[7:4];
      default: return w[3:0];
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  assign accept = in_valid && in_ready;
  assign over   = in_time > 14'd9999;

  // Decimal digits are computed once at accept so the emit path is a plain mux.
  always_comb begin
    t_clip = over ? 14'd9999 : in_time;
    t_d3   = 4'(t_clip / 14'd1000);
    t_d2   = 4'((t_clip / 14'd100) % 14'd10);
    t_d1   = 4'((t_clip / 14'd10) % 14'd10);
    t_d0   = 4'(t_clip % 14'd10);
    if (t_clip >= 14'd1000)     t_len = 3'd4;
    else if (t_clip >= 14'd100) t_len = 3'd3;
    else if (t_clip >= 14'd10)  t_len = 3'd2;
    else                        t_len = 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      kind_q    <= 1'b0;
      tdig_q[0] <= 4'd0;
      tdig_q[1] <= 4'd0;
      tdig_q[2] <= 4'd0;
      tdig_q[3] <= 4'd0;
      tlen_q    <= 3'd1;
      rtens_q   <= 4'd0;
      rones_q   <= 4'd0;
      rtwo_q    <= 1'b0;
      pc_q      <= 32'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      sat_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= accept && over;
      if (accept) begin
        kind_q    <= in_kind;
        tdig_q[0] <= t_d0;
        tdig_q[1] <= t_d1;
        tdig_q[2] <= t_d2;
        tdig_q[3] <= t_d3;
        tlen_q    <= t_len;
        rtens_q   <= 4'(in_reg / 5'd10);
        rones_q   <= 4'(in_reg % 5'd10);
        rtwo_q    <= in_reg >= 5'd10;
        pc_q      <= in_pc;
        addr_q    <= in_addr;
        data_q    <= in_data;
      end
    end
  end

  // Each state is one text segment; idx_q walks the characters inside it.
  always_comb begin
    seg_last = 1'b1;
    seg_next = S_IDLE;
    case (state_q)
      S_CARET:  seg_next = S_TIME;
      S_TIME: begin
        seg_last = (idx_q == tlen_q - 3'd1);
        seg_next = S_AT;
      end
      S_AT:     seg_next = S_PC;
      S_PC: begin
        seg_last = (idx_q == 3'd7);
        seg_next = S_COLON;
      end
      S_COLON:  seg_next = S_SPACE;
      S_SPACE:  seg_next = S_MARK;
      S_MARK:   seg_next = kind_q ? S_ADDR : S_REGNUM;
      S_REGNUM: begin
        seg_last = (idx_q == {2'b00, rtwo_q});
        seg_next = S_ARROW;
      end
      S_ADDR: begin
        seg_last = (idx_q == 3'd7);
        seg_next = S_ARROW;
      end
      S_ARROW: begin
        seg_last = (idx_q == 3'd3);
        seg_next = S_DATA;
      end
      S_DATA: begin
        seg_last = (idx_q == 3'd7);
        seg_next = S_HASH;
      end
`ifdef TRACE_NEWLINE_EN
      S_HASH:   seg_next = S_NL;
`else
      S_HASH:   seg_next = S_IDLE;
`endif
      default:  seg_next = S_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == S_IDLE) begin
      if (in_valid) begin
        state_d = S_CARET;
        idx_d   = 3'd0;
      end
    end else if (char_ready) begin
      if (seg_last) begin
        state_d = seg_next;
        idx_d   = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  assign t_sel = 2'(tlen_q - 3'd1 - idx_q);

  always_comb begin
    char = 8'h00;
    case (state_q)
      S_CARET:  char = 8'h5e;
      S_TIME:   char = dec_char(tdig_q[t_sel]);
      S_AT:     char = 8'h40;
      S_PC:     char = hex_char(nib_sel(pc_q, idx_q));
      S_COLON:  char = 8'h3a;
      S_SPACE:  char = 8'h20;
      S_MARK:   char = kind_q ? 8'h2a : 8'h24;
      S_REGNUM: char = dec_char((rtwo_q && idx_q == 3'd0) ? rtens_q : rones_q);
      S_ADDR:   char = hex_char(nib_sel(addr_q, idx_q));
      S_ARROW: begin
        case (idx_q[1:0])
          2'd1:    char = 8'h3c;
          2'd2:    char = 8'h3d;
          default: char = 8'h20;
        endcase
      end
      S_DATA:   char = hex_char(nib_sel(data_q, idx_q));
      S_HASH:   char = 8'h23;
      S_NL:     char = 8'h0a;
      default:  char = 8'h00;
    endcase
  end

  assign char_valid  = (state_q != S_IDLE);
  assign in_ready    = (state_q == S_IDLE);
  assign sat         = sat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_trace_formatter.sv
// Bench for cpu_trace_formatter: table of records with hand-written expected text,
// plus backpressure and mid-record reset sequences.
module tb_cpu_trace_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_reg;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  char;
  logic        char_valid;
  logic        char_ready;
  logic        sat;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  cpu_trace_formatter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_time    (in_time),
    .in_pc      (in_pc),
    .in_reg     (in_reg),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .char       (char),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .sat        (sat),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        kind;
    logic [13:0] t;
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] addr;
    logic [31:0] data;
    string       exp;
    logic        sat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  task automatic send(input int i, input int hold_at, input int abort_at);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    string      s;
    string      gs;
    int         cycles;
    int         hold_n;
    bit         ir_bad;
    bit         bad;

    s = vecs[i].exp;
    for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
`ifdef TRACE_NEWLINE_EN
    exp_q.push_back(8'h0a);
`endif

    @(negedge clk);
    in_kind    = vecs[i].kind;
    in_time    = vecs[i].t;
    in_pc      = vecs[i].pc;
    in_reg     = vecs[i].rg;
    in_addr    = vecs[i].addr;
    in_data    = vecs[i].data;
    in_valid   = 1'b1;
    char_ready = 1'b1;
    chk($sformatf("in_ready_idle[%0d]", i), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_kind  = ~in_kind;
    in_time  = ~in_time;
    in_pc    = ~in_pc;
    in_reg   = ~in_reg;
    in_addr  = ~in_addr;
    in_data  = ~in_data;
    chk($sformatf("sat_pulse[%0d]", i), sat, vecs[i].sat);
    chk($sformatf("first_char[%0d]", i), {char_valid, char}, {1'b1, 8'h5e});

    cycles = 0;
    hold_n = 0;
    ir_bad = 0;
    while (char_valid && cycles < 200) begin
      if (in_ready) ir_bad = 1;
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_char_valid", char_valid, 0);
        chk("abort_char", char, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_sat", sat, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (hold_at >= 0 && got_q.size() == hold_at && hold_n < 3) begin
        chk($sformatf("hold_char[%0d]", hold_n), char, exp_q[hold_at]);
        char_ready = 1'b0;
        hold_n++;
      end else begin
        char_ready = 1'b1;
      end
      if (char_ready) got_q.push_back(char);
      if (cycles == 1) chk($sformatf("sat_width[%0d]", i), sat, 0);
      @(posedge clk); #1;
      cycles++;
    end

    chk($sformatf("timeout[%0d]", i), char_valid, 0);
    chk($sformatf("in_ready_busy[%0d]", i), ir_bad, 0);
    chk($sformatf("length[%0d]", i), got_q.size(), exp_q.size());
    bad = (got_q.size() != exp_q.size());
    gs = "";
    for (int k = 0; k < got_q.size(); k++) begin
      gs = $sformatf("%s%c", gs, got_q[k]);
      if (k < exp_q.size() && got_q[k] !== exp_q[k]) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL stream[%0d]: got \"%s\" expected \"%s\"", i, gs, s);
    end
    chk($sformatf("idle_after[%0d]", i), {in_ready, char_valid, char}, {1'b1, 1'b0, 8'h00});
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{1'b0, 14'd0,     32'h00003000, 5'd1,  32'h0,        32'h00000001,
                "^0@00003000: $1 <= 00000001#", 1'b0};
    vecs[1] = '{1'b1, 14'd1234,  32'hdeadbeef, 5'd0,  32'h0000abcd, 32'hffffffff,
                "^1234@deadbeef: *0000abcd <= ffffffff#", 1'b0};
    vecs[2] = '{1'b0, 14'd12000, 32'h12345678, 5'd31, 32'h0,        32'hcafef00d,
                "^9999@12345678: $31 <= cafef00d#", 1'b1};
    vecs[3] = '{1'b1, 14'd9999,  32'h00000000, 5'd0,  32'hffffffff, 32'h00000000,
                "^9999@00000000: *ffffffff <= 00000000#", 1'b0};
    vecs[4] = '{1'b0, 14'd10,    32'ha0b1c2d3, 5'd10, 32'h0,        32'h00000000,
                "^10@a0b1c2d3: $10 <= 00000000#", 1'b0};
    vecs[5] = '{1'b0, 14'd999,   32'h00000001, 5'd0,  32'h0,        32'h89abcdef,
                "^999@00000001: $0 <= 89abcdef#", 1'b0};
    vecs[6] = '{1'b1, 14'd16383, 32'hffffffff, 5'd0,  32'h00000010, 32'h7fffffff,
                "^9999@ffffffff: *00000010 <= 7fffffff#", 1'b1};
    vecs[7] = '{1'b0, 14'd100,   32'h0000ffff, 5'd9,  32'h0,        32'h00000010,
                "^100@0000ffff: $9 <= 00000010#", 1'b0};

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_kind    = 1'b0;
    in_time    = 14'd0;
    in_pc      = 32'd0;
    in_reg     = 5'd0;
    in_addr    = 32'd0;
    in_data    = 32'd0;
    char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_char_valid", char_valid, 0);
    chk("reset_char", char, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_sat", sat, 0);
    chk("reset_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_output", {char_valid, char}, 0);

    for (int i = 0; i < 8; i++) send(i, -1, -1);

    // Backpressure on PC digit 4 ('d' of deadbeef) for 3 cycles.
    send(1, 9, -1);

    // Reset while DATA field is streaming, then a clean record.
    send(1, -1, 31);
    chk("post_abort_state", dbg_state, 0);
    send(0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
